// File: rtl/grid_mover_pkg.sv
// Shared types and defaults for the tile-grid sprite mover.
package grid_mover_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FIRST_WAIT = 2'd1,
        ST_REPEAT     = 2'd2
    } state_t;

    localparam int DEF_TILE  = 16;
    localparam int DEF_X_MAX = 640;
    localparam int DEF_Y_MAX = 480;

    // held bit order: [0]=up [1]=down [2]=left [3]=right; caller ensures a key is held
    function automatic dir_t pick_dir(input logic [3:0] held);
        if (held[0])      return DIR_UP;
        else if (held[1]) return DIR_DOWN;
        else if (held[2]) return DIR_LEFT;
        else              return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/grid_mover_key_sync.sv
// N-bit two-flop synchroniser; resets to all-ones so active-low keys read released.
module grid_mover_key_sync #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/grid_mover.sv
// Key-driven tile mover: move on press, auto-repeat after a delay, clamp to screen.
module grid_mover
    import grid_mover_pkg::*;
#(
    parameter int TILE         = DEF_TILE,
    parameter int X_MAX        = DEF_X_MAX,
    parameter int Y_MAX        = DEF_Y_MAX,
    parameter int START_X      = 320,
    parameter int START_Y      = 240,
    parameter int FIRST_DELAY  = 12_500_000,
    parameter int REPEAT_DELAY = 4_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       game_state,
    input  logic       keyUp,
    input  logic       keyDown,
    input  logic       keyLeft,
    input  logic       keyRight,
    output logic [9:0] out_x,
    output logic [9:0] out_y,
    output logic [9:0] carac_leftLimit,
    output logic [9:0] carac_rightLimit,
    output logic [9:0] carac_topLimit,
    output logic [9:0] carac_bottomLimit,
    output logic       moved,
    output logic       bumped,
    output logic [1:0] dir
);

    localparam int MAX_DELAY = (FIRST_DELAY > REPEAT_DELAY) ? FIRST_DELAY : REPEAT_DELAY;
    localparam int CW        = $clog2(MAX_DELAY) + 1;
    // Loading DELAY-1 and firing at zero gives exactly DELAY cycles between moves
    localparam logic [CW-1:0] FIRST_LOAD  = CW'(FIRST_DELAY - 1);
    localparam logic [CW-1:0] REPEAT_LOAD = CW'(REPEAT_DELAY - 1);
    localparam logic [10:0]   TILE11      = 11'(TILE);
    localparam logic [10:0]   X_LIM       = 11'(X_MAX - TILE);
    localparam logic [10:0]   Y_LIM       = 11'(Y_MAX - TILE);
    localparam logic [9:0]    TILE10      = 10'(TILE);

    logic [3:0]    keys_n;
    logic [3:0]    held;
    logic          any_held;
    dir_t          sel;
    dir_t          dir_q;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          restart;
    logic          fire;
    logic          ok;
    logic [9:0]    nx, ny;

    grid_mover_key_sync #(.N(4)) u_sync (
        .clk   (CLOCK_50),
        .rst_n (reset),
        .d     ({keyRight, keyLeft, keyDown, keyUp}),
        .q     (keys_n)
    );

    assign held     = ~keys_n;
    assign any_held = |held;
    assign sel      = pick_dir(held);
    assign restart  = (state == ST_IDLE) || (sel != dir_q);
    assign fire     = !game_state && armed && any_held && (restart || cnt == '0);

    // Bounds are checked one bit wider than the position so nothing can wrap
    always_comb begin
        ok = 1'b0;
        nx = out_x;
        ny = out_y;
        case (sel)
            DIR_UP: begin
                ok = {1'b0, out_y} >= TILE11;
                ny = out_y - TILE10;
            end
            DIR_DOWN: begin
                ok = ({1'b0, out_y} + TILE11) <= Y_LIM;
                ny = out_y + TILE10;
            end
            DIR_LEFT: begin
                ok = {1'b0, out_x} >= TILE11;
                nx = out_x - TILE10;
            end
            default: begin
                ok = ({1'b0, out_x} + TILE11) <= X_LIM;
                nx = out_x + TILE10;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            out_x  <= 10'(START_X);
            out_y  <= 10'(START_Y);
            moved  <= 1'b0;
            bumped <= 1'b0;
            dir_q  <= DIR_UP;
            state  <= ST_IDLE;
            cnt    <= '0;
            armed  <= 1'b0;
        end else begin
            moved  <= 1'b0;
            bumped <= 1'b0;
            if (game_state) begin
                out_x <= 10'(START_X);
                out_y <= 10'(START_Y);
                state <= ST_IDLE;
                cnt   <= '0;
                armed <= 1'b0;
            end else if (!any_held) begin
                state <= ST_IDLE;
                cnt   <= '0;
                armed <= 1'b1;
            end else if (fire) begin
                dir_q <= sel;
                if (ok) begin
                    out_x <= nx;
                    out_y <= ny;
                    moved <= 1'b1;
                end else begin
                    bumped <= 1'b1;
                end
                if (restart) begin
                    state <= ST_FIRST_WAIT;
                    cnt   <= FIRST_LOAD;
                end else begin
                    state <= ST_REPEAT;
                    cnt   <= REPEAT_LOAD;
                end
            end else if (state != ST_IDLE) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign dir               = dir_q;
    assign carac_leftLimit   = out_x;
    assign carac_rightLimit  = out_x + 10'(TILE - 1);
    assign carac_topLimit    = out_y;
    assign carac_bottomLimit = out_y + 10'(TILE - 1);

endmodule

// File: tb/tb_grid_mover.sv
// Directed bench for grid_mover with short delays (FIRST=10, REPEAT=4).
module tb_grid_mover;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       game_state = 1'b0;
    logic       keyUp = 1'b1, keyDown = 1'b1, keyLeft = 1'b1, keyRight = 1'b1;
    logic [9:0] out_x, out_y, lim_l, lim_r, lim_t, lim_b;
    logic       moved, bumped;
    logic [1:0] dir;

    int checks = 0;
    int errors = 0;

    grid_mover #(
        .TILE(16), .X_MAX(640), .Y_MAX(480), .START_X(320), .START_Y(240),
        .FIRST_DELAY(10), .REPEAT_DELAY(4)
    ) dut (
        .CLOCK_50          (clk),
        .reset             (reset),
        .game_state        (game_state),
        .keyUp             (keyUp),
        .keyDown           (keyDown),
        .keyLeft           (keyLeft),
        .keyRight          (keyRight),
        .out_x             (out_x),
        .out_y             (out_y),
        .carac_leftLimit   (lim_l),
        .carac_rightLimit  (lim_r),
        .carac_topLimit    (lim_t),
        .carac_bottomLimit (lim_b),
        .moved             (moved),
        .bumped            (bumped),
        .dir               (dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        // async reset asserted between edges
        #3 reset = 1'b0;
        #1;
        chk("rst_x", out_x, 320);
        chk("rst_y", out_y, 240);
        chk("rst_moved", moved, 0);
        chk("rst_bumped", bumped, 0);
        chk("rst_dir", dir, 0);
        chk("rst_lim_l", lim_l, 320);
        chk("rst_lim_r", lim_r, 335);
        chk("rst_lim_t", lim_t, 240);
        chk("rst_lim_b", lim_b, 255);
        #8 reset = 1'b1;
        tick(3);

        // hold right: move at 3rd edge, repeat 10 later, then every 4
        keyRight = 1'b0;
        tick(2);
        chk("r_early_x", out_x, 320);
        chk("r_early_moved", moved, 0);
        tick(1);
        chk("r_first_x", out_x, 336);
        chk("r_first_moved", moved, 1);
        chk("r_first_dir", dir, 3);
        tick(1);
        chk("r_pulse_end", moved, 0);
        tick(8);
        chk("r_wait_x", out_x, 336);
        tick(1);
        chk("r_rep1_x", out_x, 352);
        chk("r_rep1_moved", moved, 1);
        tick(3);
        chk("r_rep_wait_x", out_x, 352);
        tick(1);
        chk("r_rep2_x", out_x, 368);
        tick(4);
        chk("r_rep3_x", out_x, 384);
        keyRight = 1'b1;
        tick(10);
        chk("r_release_x", out_x, 384);
        chk("r_release_y", out_y, 240);

        // up+right together: up wins; drop up -> immediate right move
        keyUp = 1'b0;
        keyRight = 1'b0;
        tick(3);
        chk("ur_y", out_y, 224);
        chk("ur_x", out_x, 384);
        chk("ur_dir", dir, 0);
        keyUp = 1'b1;
        tick(2);
        chk("ur_pre_x", out_x, 384);
        tick(1);
        chk("ur_switch_x", out_x, 400);
        chk("ur_switch_y", out_y, 224);
        chk("ur_switch_dir", dir, 3);
        keyRight = 1'b1;
        tick(4);

        // game_state during repeat, key held across restart must not move
        keyDown = 1'b0;
        tick(3);
        chk("d_first_y", out_y, 240);
        tick(10);
        chk("d_rep_y", out_y, 256);
        tick(2);
        game_state = 1'b1;
        tick(1);
        chk("gs_x", out_x, 320);
        chk("gs_y", out_y, 240);
        chk("gs_moved", moved, 0);
        tick(3);
        game_state = 1'b0;
        tick(20);
        chk("gs_held_y", out_y, 240);
        chk("gs_held_x", out_x, 320);
        keyDown = 1'b1;
        tick(4);
        keyDown = 1'b0;
        tick(3);
        chk("gs_repress_y", out_y, 256);
        chk("gs_repress_moved", moved, 1);
        keyDown = 1'b1;
        tick(4);

        // walk to the left edge, then bump
        keyLeft = 1'b0;
        cyc = 0;
        while (out_x != 10'd0 && cyc < 300) begin
            tick(1);
            cyc++;
        end
        chk("walk_left_x", out_x, 0);
        keyLeft = 1'b1;
        tick(4);
        keyLeft = 1'b0;
        tick(3);
        chk("bl_bumped", bumped, 1);
        chk("bl_moved", moved, 0);
        chk("bl_x", out_x, 0);
        chk("bl_dir", dir, 2);
        tick(1);
        chk("bl_pulse_end", bumped, 0);
        keyLeft = 1'b1;
        tick(4);

        // walk to the right edge, then bump without wrap
        keyRight = 1'b0;
        cyc = 0;
        while (out_x != 10'd624 && cyc < 400) begin
            tick(1);
            cyc++;
        end
        chk("walk_right_x", out_x, 624);
        keyRight = 1'b1;
        tick(4);
        keyRight = 1'b0;
        tick(3);
        chk("br_bumped", bumped, 1);
        chk("br_moved", moved, 0);
        chk("br_x", out_x, 624);
        chk("br_lim_r", lim_r, 639);
        chk("br_dir", dir, 3);
        tick(8);
        chk("br_hold_x", out_x, 624);
        keyRight = 1'b1;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
